// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: ISA opcodes, instruction field positions and sequencer states
package program_sequencer_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_OUT  = 4'hF;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 9;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_OUTW, S_HALT} state_e;
endpackage

// File: rtl/program_sequencer_seq_decode.sv
// seq_decode: combinational split of an instruction word into class flags and fields
module seq_decode
    import program_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    output logic        is_nop,
    output logic        is_addi,
    output logic        is_out,
    output logic        is_illegal,
    output logic [2:0]  reg_idx,
    output logic [7:0]  imm
);
    logic [3:0] op;
    logic       unused_bit;
    assign unused_bit = ir[8];
    always_comb begin
        op         = ir[OP_MSB:OP_LSB];
        is_nop     = op == OP_NOP;
        is_addi    = op == OP_ADDI;
        is_out     = op == OP_OUT;
        is_illegal = !(is_nop || is_addi || is_out);
        reg_idx    = ir[REG_MSB:REG_LSB];
        imm        = ir[IMM_MSB:IMM_LSB];
    end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: multi-cycle fetch/decode/execute sequencer over an 8-entry ROM
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter logic WRAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    output logic [2:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [2:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [2:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);
    state_e      state_q, state_d;
    logic [2:0]  pc_q, pc_d, raddr_q, raddr_d;
    logic [15:0] ir_q, ir_d;
    logic        out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        is_addi, is_out, is_illegal, unused_nop, advance;
    logic [2:0]  reg_idx;
    logic [7:0]  imm;

    seq_decode u_dec (
        .ir         (ir_q),
        .is_nop     (unused_nop),
        .is_addi    (is_addi),
        .is_out     (is_out),
        .is_illegal (is_illegal),
        .reg_idx    (reg_idx),
        .imm        (imm)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        raddr_d     = raddr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        illegal_d   = illegal_q;
        advance     = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = 3'd0;
        rf_wdata    = 8'd0;
        case (state_q)
            S_IDLE:   state_d = (run || step) ? S_FETCH : S_IDLE;
            S_FETCH: begin
                ir_d    = rom_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                raddr_d = reg_idx;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                rf_we     = is_addi;
                rf_waddr  = is_addi ? reg_idx : 3'd0;
                rf_wdata  = is_addi ? rf_rdata + imm : 8'd0;
                illegal_d = illegal_q | is_illegal;
                if (is_out) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rf_rdata;
                    state_d     = S_OUTW;
                end else begin
                    advance = 1'b1;
                end
            end
            S_OUTW: begin
                out_valid_d = out_ready ? 1'b0 : out_valid_q;
                advance     = out_ready;
            end
            default: state_d = state_q;
        endcase
        // run is resampled only once the instruction retires
        if (advance) begin
            if (!WRAP_EN && pc_q == 3'd7) begin
                state_d = S_HALT;
            end else begin
                pc_d    = pc_q + 3'd1;
                state_d = run ? S_FETCH : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= 3'd0;
            ir_q        <= 16'd0;
            raddr_q     <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            raddr_q     <= raddr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign rom_addr  = pc_q;
    assign pc        = pc_q;
    assign rf_raddr  = raddr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign illegal   = illegal_q;
    assign busy      = state_q != S_IDLE && state_q != S_HALT;
    assign halted    = state_q == S_HALT;
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter WRAP_EN, default 1; 1 = PC wraps 7->0, 0 = halt after executing address 7.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 run  in  1  level; 1 = fetch/execute continuously.
REQ-005 step  in  1  one-cycle pulse; executes exactly one instruction when sampled in IDLE with run=0.
REQ-006 rom_addr  out  3  program ROM address, equals pc.
REQ-007 rom_data  in  16  combinational ROM instruction for rom_addr.
REQ-008 rf_raddr  out  3  register-file read index.
REQ-009 rf_rdata  in  8  register-file read data, combinational from rf_raddr.
REQ-010 rf_we / rf_waddr / rf_wdata  out  1/3/8  register-file write port.
REQ-011 out_valid / out_data  out  1/8  output stream; out_ready  in  1  consumer accept.
REQ-012 pc  out  3; busy  out  1 (state not IDLE/HALT); halted  out  1; illegal  out  1 (sticky).

Function
REQ-013 ISA: opcode ir[15:12]; rd/rs ir[11:9]; imm ir[7:0]; 0000 NOP, 0001 ADDI rd,imm, 1111 OUT rs; all other opcodes illegal.
REQ-014 States: IDLE, FETCH, DECODE, EXEC, OUTW, HALT.
REQ-015 IDLE -> FETCH when run=1 or step=1; otherwise hold.
REQ-016 FETCH: ir <= rom_data (addr = pc); -> DECODE.
REQ-017 DECODE: rf_raddr = ir[11:9]; -> EXEC.
REQ-018 EXEC NOP: pc advance; no side effects.
REQ-019 EXEC ADDI: rf_we=1 for exactly this cycle, rf_waddr=ir[11:9], rf_wdata=(rf_rdata+imm) mod 256; pc advance.
REQ-020 EXEC OUT: out_data <= rf_rdata, out_valid <= 1; -> OUTW; pc not yet advanced.
REQ-021 OUTW: out_valid and out_data held stable until out_valid&out_ready; on handshake out_valid <= 0, pc advance.
REQ-022 EXEC illegal: illegal <= 1 (sticky until reset); otherwise executes as NOP.
REQ-023 pc advance: pc <= pc+1 mod 8; if WRAP_EN=0 and pc==7, -> HALT instead.
REQ-024 After pc advance: -> FETCH if run=1, else IDLE (run=0 mid-instruction completes that instruction only).
REQ-025 Latency: NOP/ADDI/illegal 3 cycles each; OUT 4 cycles with out_ready=1, +1 per stalled cycle.
REQ-026 step ignored unless in IDLE with run=0; run=1 and step=1 together behave as run.
REQ-027 HALT: no fetch, halted=1, busy=0; exits only by reset.
REQ-028 rf_we never asserted outside EXEC; out_valid never asserted outside OUTW.

Reset
REQ-029 rst_n=0 at an edge: state IDLE, pc=0, ir=0, out_valid=0, out_data=0, rf_we=0, illegal=0, halted=0; applies mid-instruction, including OUTW (pending output discarded).
REQ-030 rf_raddr, rf_waddr, rf_wdata reset to 0.

Structure
REQ-031 Shared package holds opcode constants (OP_NOP, OP_ADDI, OP_OUT), field bit positions, and the state enumeration.
REQ-032 Single sub-module seq_decode: combinational ir -> {is_nop, is_addi, is_out, is_illegal, reg_idx, imm}.

Verification
REQ-033 ROM {addi r1 5; addi r2 10; nop; nop; out r1; out r2; out r1; out r2}, RF zeroed, run=1, out_ready=1 -> writes r1=5, r2=10; outputs 5,10,5,10; pc wraps to 0; program repeats, writes r1=10, r2=20.
REQ-034 Same program, out_ready=0 for 5 cycles at first OUT -> out_valid high and out_data=5 stable throughout; pc stays 4; single transfer once ready.
REQ-035 WRAP_EN=0, run=1 -> after out r2 at address 7, halted=1, pc=7, no further rf_we or out_valid.
REQ-036 run=0, three step pulses -> exactly three instructions execute, pc=3, busy low between steps.
REQ-037 r1 preloaded 0xFE, addi r1 5 -> rf_wdata=0x03; instruction 0x2000 -> illegal=1, pc advances, no writes.
REQ-038 rst_n low during OUTW -> next edge out_valid=0, pc=0, state IDLE.
